ppu_pixel_gearbox_ctrl: RTL and testbench

Sequencer for ppu_pixel_gearbox. Per span it accepts 32-bit pixel words from the PPU fetch path through a valid/ready handshake and loads them into the gearbox. It then issues one gearbox shift per consumed pixel and presents width-masked pixels downstream through a second valid/ready handshake. It owns the pixels-per-word and pixels-per-span counting, the first-word pixel skip, and the done signalling.

---
 rtl/ppu_pixel_gearbox_ctrl.sv | 152 +++++++++++++++
 tb/tb_ppu_pixel_gearbox_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_pixel_gearbox_ctrl.sv
// Span sequencer for ppu_pixel_gearbox: fetches 32-bit pixel words, drops the
// first-word skip pixels, then emits one width-masked pixel per accepted shift.
module ppu_pixel_gearbox_ctrl #(
  parameter int W_DATA    = 32,
  parameter int W_PIX_MAX = 16,
  parameter int W_COUNT   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           pix_mode,
  input  logic [W_COUNT-1:0]   pix_count,
  input  logic [4:0]           first_skip,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [W_DATA-1:0]    in_data,
  output logic [W_DATA-1:0]    gb_din,
  output logic                 gb_din_vld,
  output logic [2:0]           gb_shamt,
  input  logic [W_PIX_MAX-1:0] gb_dout,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [W_PIX_MAX-1:0] out_data
);

  // Handshakes: a word/pixel transfers in a cycle where vld and rdy are both high.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SKIP, S_EMIT} state_e;

  state_e               state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [W_COUNT-1:0]   remaining_q, remaining_d;
  logic [4:0]           first_skip_q, first_skip_d;
  logic [5:0]           word_left_q, word_left_d;
  logic [4:0]           skip_left_q, skip_left_d;
  logic                 first_q, first_d;
  logic                 done_q, done_d;

  logic [5:0]           ppw;
  logic [5:0]           ppw_m1;
  logic [4:0]           skip_eff;
  logic [2:0]           shift_code;
  logic                 in_hs;
  logic                 out_hs;
  logic [W_PIX_MAX-1:0] pix_mask;

  assign ppw        = 6'd32 >> mode_q;
  assign ppw_m1     = ppw - 6'd1;
  assign skip_eff   = first_skip_q & ppw_m1[4:0];
  assign shift_code = mode_q + 3'd1;
  assign in_hs      = in_vld & in_rdy;
  assign out_hs     = out_vld & out_rdy;

  assign gb_din     = in_data;
  assign gb_din_vld = in_hs;
  assign done       = done_q;
  assign out_data   = gb_dout & pix_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 3'd0;
      remaining_q  <= '0;
      first_skip_q <= 5'd0;
      word_left_q  <= 6'd0;
      skip_left_q  <= 5'd0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      remaining_q  <= remaining_d;
      first_skip_q <= first_skip_d;
      word_left_q  <= word_left_d;
      skip_left_q  <= skip_left_d;
      first_q      <= first_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    remaining_d  = remaining_q;
    first_skip_d = first_skip_q;
    word_left_d  = word_left_q;
    skip_left_d  = skip_left_q;
    first_d      = first_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d       = (pix_mode > 3'd4) ? 3'd4 : pix_mode;
          remaining_d  = pix_count;
          first_skip_d = first_skip;
          first_d      = 1'b1;
          if (pix_count == '0) done_d  = 1'b1;
          else                 state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (in_hs) begin
          word_left_d = ppw;
          first_d     = 1'b0;
          if (first_q && (skip_eff != 5'd0)) begin
            skip_left_d = skip_eff;
            state_d     = S_SKIP;
          end else begin
            state_d = S_EMIT;
          end
        end
      end
      S_SKIP: begin
        skip_left_d = skip_left_q - 5'd1;
        word_left_d = word_left_q - 6'd1;
        if (skip_left_q == 5'd1) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_hs) begin
          remaining_d = remaining_q - 1'b1;
          word_left_d = word_left_q - 6'd1;
          // Leftover pixels in the last word are simply abandoned.
          if (remaining_q == W_COUNT'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (word_left_q == 6'd1) begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    in_rdy   = (state_q == S_FETCH);
    out_vld  = (state_q == S_EMIT);
    gb_shamt = 3'd0;
    if (state_q == S_SKIP)                gb_shamt = shift_code;
    if ((state_q == S_EMIT) && out_rdy)   gb_shamt = shift_code;
    case (mode_q)
      3'd0:    pix_mask = 16'h0001;
      3'd1:    pix_mask = 16'h0003;
      3'd2:    pix_mask = 16'h000F;
      3'd3:    pix_mask = 16'h00FF;
      default: pix_mask = 16'hFFFF;
    endcase
  end

endmodule

// File: tb/tb_ppu_pixel_gearbox_ctrl.sv
// Directed bench for ppu_pixel_gearbox_ctrl with a behavioural gearbox attached.
module tb_ppu_pixel_gearbox_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  pix_mode = 3'd0;
  logic [9:0]  pix_count = 10'd0;
  logic [4:0]  first_skip = 5'd0;
  logic        busy, done;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [31:0] in_data = 32'd0;
  logic [31:0] gb_din;
  logic        gb_din_vld;
  logic [2:0]  gb_shamt;
  logic [15:0] gb_dout;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [15:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  ppu_pixel_gearbox_ctrl #(.W_DATA(32), .W_PIX_MAX(16), .W_COUNT(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_mode(pix_mode),
    .pix_count(pix_count), .first_skip(first_skip), .busy(busy), .done(done),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .gb_din(gb_din),
    .gb_din_vld(gb_din_vld), .gb_shamt(gb_shamt), .gb_dout(gb_dout),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Behavioural gearbox: load on din_vld, shift right by 2^(shamt-1) otherwise.
  logic [31:0] gb_reg = 32'd0;
  always @(posedge clk) begin
    if (gb_din_vld) gb_reg <= gb_din;
    else if (gb_shamt != 3'd0) gb_reg <= gb_reg >> (1 << (gb_shamt - 3'd1));
  end
  assign gb_dout = gb_reg[15:0];

  // Span driver/monitor state
  logic [31:0] word_q[$];
  logic        rdy_q[$];
  logic [15:0] got_q[$];
  int          got_cyc_q[$];
  logic [15:0] exp_q[$];
  int hs_cnt, in_rdy_cyc, done_cyc, done_busy, timed_out;
  int skip_cyc, skip_bad_shamt, first_vld_cyc, stall_err, shamt_off_hs;
  int shamt_bad, high_bits_err, both_err;

  task automatic run_span(input int budget, input int inj_cyc);
    int cyc = 0;
    bit seen_done = 0;
    bit holding = 0;
    logic [15:0] held = 16'd0;
    hs_cnt = 0; in_rdy_cyc = 0; done_cyc = -1; done_busy = 0; timed_out = 0;
    skip_cyc = 0; skip_bad_shamt = 0; first_vld_cyc = -1; stall_err = 0;
    shamt_off_hs = 0; shamt_bad = 0; high_bits_err = 0; both_err = 0;
    got_q.delete(); got_cyc_q.delete();
    while (!seen_done && cyc < budget) begin
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin pix_mode = 3'd0; pix_count = 10'd5; end
      in_vld  = (word_q.size() > 0);
      in_data = (word_q.size() > 0) ? word_q[0] : 32'd0;
      out_rdy = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      #1;
      if (in_rdy) in_rdy_cyc++;
      if (gb_din_vld && gb_shamt != 3'd0) both_err++;
      if (in_vld && in_rdy) begin hs_cnt++; void'(word_q.pop_front()); end
      if (busy && !in_rdy && !out_vld && gb_shamt != 3'd0) begin
        skip_cyc++;
        if (gb_shamt != dut.shift_code) skip_bad_shamt++;
      end
      if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_vld && holding && out_data !== held) stall_err++;
      holding = out_vld && !out_rdy;
      held = out_data;
      if (gb_shamt != 3'd0 && out_vld && !out_rdy) shamt_off_hs++;
      if (out_vld && out_rdy) begin
        got_q.push_back(out_data);
        got_cyc_q.push_back(cyc);
      end
      if (done) begin seen_done = 1; done_cyc = cyc; done_busy = busy; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    timed_out = !seen_done;
  endtask

  task automatic kick(input logic [2:0] m, input logic [9:0] c, input logic [4:0] s);
    pix_mode = m; pix_count = c; first_skip = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy, done, in_rdy, out_vld, gb_din_vld, gb_shamt} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {busy, done, in_rdy, out_vld, gb_din_vld, gb_shamt});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_pixels(input string name);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s_pix%0d: got %h required %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_8bpp(input string name);
    word_q = '{32'h4433_2211};
    exp_q  = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    kick(3'd3, 10'd4, 5'd0);
    run_span(40, -1);
    n_cmp++;
    if (timed_out) begin n_err++; $display("FAIL %s_timeout: got no done required done", name); end
    check_pixels(name);
    n_cmp++;
    if (hs_cnt != 1) begin n_err++; $display("FAIL %s_fetches: got %0d required 1", name, hs_cnt); end
    n_cmp++;
    if (got_cyc_q.size() == 4 && (got_cyc_q[0] != 1 || got_cyc_q[3] != 4)) begin
      n_err++;
      $display("FAIL %s_timing: got first %0d last %0d required 1 4", name, got_cyc_q[0], got_cyc_q[3]);
    end
    n_cmp++;
    if (done_cyc != 5 || done_busy != 0) begin
      n_err++;
      $display("FAIL %s_done: got cyc %0d busy %0d required cyc 5 busy 0", name, done_cyc, done_busy);
    end
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_pulse: got done %b busy %b required 0 0", name, done, busy);
    end
  endtask

  task automatic test_1bpp();
    word_q = '{32'h0000_0005, 32'h0000_00FF};
    exp_q.delete();
    exp_q.push_back(16'd1); exp_q.push_back(16'd0); exp_q.push_back(16'd1);
    for (int i = 3; i < 32; i++) exp_q.push_back(16'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'd1);
    kick(3'd0, 10'd40, 5'd0);
    run_span(200, -1);
    check_pixels("bpp1");
    n_cmp++;
    if (hs_cnt != 2) begin n_err++; $display("FAIL bpp1_fetches: got %0d required 2", hs_cnt); end
    n_cmp++;
    if (done_cyc != 42) begin n_err++; $display("FAIL bpp1_done_cyc: got %0d required 42", done_cyc); end
    n_cmp++;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i][15:1] != 15'd0) high_bits_err++;
    if (high_bits_err != 0) begin n_err++; $display("FAIL bpp1_mask: got %0d wide pixels required 0", high_bits_err); end
  endtask

  task automatic test_skip();
    word_q = '{32'h8765_4321};
    exp_q  = '{16'h0004, 16'h0005};
    kick(3'd2, 10'd2, 5'd3);
    run_span(40, -1);
    check_pixels("skip");
    n_cmp++;
    if (skip_cyc != 3 || skip_bad_shamt != 0) begin
      n_err++;
      $display("FAIL skip_cycles: got %0d (bad shamt %0d) required 3 (0)", skip_cyc, skip_bad_shamt);
    end
    n_cmp++;
    if (first_vld_cyc != 4 || done_cyc != 6) begin
      n_err++;
      $display("FAIL skip_timing: got vld %0d done %0d required 4 6", first_vld_cyc, done_cyc);
    end
  endtask

  task automatic test_stall();
    word_q = '{32'hBBBB_AAAA, 32'hDDDD_CCCC};
    rdy_q  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_q  = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    kick(3'd4, 10'd3, 5'd0);
    run_span(60, -1);
    rdy_q.delete();
    check_pixels("stall");
    n_cmp++;
    if (stall_err != 0) begin n_err++; $display("FAIL stall_hold: got %0d changes required 0", stall_err); end
    n_cmp++;
    if (shamt_off_hs != 0) begin n_err++; $display("FAIL stall_shamt: got %0d stalled shifts required 0", shamt_off_hs); end
    n_cmp++;
    if (done_cyc != 7 || hs_cnt != 2) begin
      n_err++;
      $display("FAIL stall_done: got cyc %0d fetches %0d required 7 2", done_cyc, hs_cnt);
    end
  endtask

  task automatic test_zero_and_busy_start();
    word_q = '{32'h1234_5678};
    kick(3'd3, 10'd0, 5'd0);
    run_span(5, -1);
    n_cmp++;
    if (done_cyc != 0 || hs_cnt != 0 || in_rdy_cyc != 0) begin
      n_err++;
      $display("FAIL zero_count: got done %0d fetch %0d rdy %0d required 0 0 0", done_cyc, hs_cnt, in_rdy_cyc);
    end
    word_q = '{32'h4433_2211};
    exp_q  = '{16'h0011, 16'h0022};
    kick(3'd3, 10'd2, 5'd0);
    run_span(40, 1);
    check_pixels("busy_start");
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || in_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_ignored: got busy %b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_emit();
    word_q = '{32'h4433_2211};
    kick(3'd3, 10'd4, 5'd0);
    run_span(3, -1);
    n_cmp++;
    if (out_vld !== 1'b1) begin n_err++; $display("FAIL rst_pre_emit: got out_vld %b required 1", out_vld); end
    out_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, out_vld, in_rdy, gb_shamt} !== 6'd0) begin
      n_err++;
      $display("FAIL rst_async: got %b required 000000", {busy, out_vld, in_rdy, gb_shamt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b0;
    word_q.delete();
    @(negedge clk);
    test_8bpp("after_rst");
  endtask

  initial begin
    test_reset();
    test_8bpp("bpp8");
    test_1bpp();
    test_skip();
    test_stall();
    test_zero_and_busy_start();
    test_reset_mid_emit();
    n_cmp++;
    if (both_err != 0) begin n_err++; $display("FAIL load_and_shift: got %0d required 0", both_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
